spi_sample_capture: RTL

//   SPI mode-0 master that periodically reads one WIDTH-bit sample from an external ADC
//   and pushes it into the downstream sample FIFO (wr_en/din/full interface).

---
 rtl/spi_sample_capture.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/spi_sample_capture.sv
// spi_sample_capture
//   SPI mode-0 master that reads one WIDTH-bit word from an external ADC every
//   SAMPLE_PERIOD clock cycles and writes it into the downstream sample FIFO.
//   Words that arrive while the FIFO reports full are dropped. A saturating
//   counter records how many were dropped.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   1 = run periodic sampling
//   miso         in   ADC serial data
//   sclk         out  SPI clock, idle low
//   cs_n         out  ADC chip select, active low
//   fifo_wr_en   out  one-cycle FIFO write strobe
//   fifo_din     out  sample word, valid while fifo_wr_en=1, held otherwise
//   fifo_full    in   FIFO full flag
//   busy         out  1 from frame start through the PUSH cycle
//   overflow_cnt out  saturating count of dropped samples
module spi_sample_capture #(
  parameter int WIDTH         = 16,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int OVF_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             miso,
  output logic             sclk,
  output logic             cs_n,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_din,
  input  logic             fifo_full,
  output logic             busy,
  output logic [OVF_W-1:0] overflow_cnt
);

  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] FULL_LAST  = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, PUSH} state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             timer_tc;

  // Saturating increment: once all-ones the count sticks.
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Shift one bit in at the LSB end; the word arrives MSB first.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic b);
    return WIDTH'({v, b});
  endfunction

  assign timer_tc = (timer == TIMER_LAST);

  // Period timer: free-runs while enabled, parked at 0 otherwise so that a
  // rising enable always waits a full period before the first frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (!enable || timer_tc) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Frame FSM. div_cnt times SCLK half-periods; in SHIFT it spans a whole bit
  // period (high half then low half), so the rising edge and the sample of
  // miso both happen on the edge that restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      busy         <= 1'b0;
      overflow_cnt <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          fifo_wr_en <= 1'b0;
          // A terminal count outside IDLE is simply lost; only IDLE listens.
          if (enable && timer_tc) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
          end
        end

        SETUP: begin
          if (div_cnt == HALF_LAST) begin
            state     <= SHIFT;
            sclk      <= 1'b1;
            shift_reg <= shift_in(shift_reg, miso);
            div_cnt   <= '0;
            bit_cnt   <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (div_cnt == HALF_LAST) begin
            sclk <= 1'b0;
          end
          if (div_cnt == FULL_LAST) begin
            if (bit_cnt == BIT_LAST) begin
              // Last low half-period is over: it served as CS hold time.
              state <= PUSH;
              cs_n  <= 1'b1;
              if (!fifo_full) begin
                fifo_wr_en <= 1'b1;
                fifo_din   <= shift_reg;
              end else begin
                overflow_cnt <= sat_inc(overflow_cnt);
              end
            end else begin
              sclk      <= 1'b1;
              shift_reg <= shift_in(shift_reg, miso);
              bit_cnt   <= bit_cnt + 1'b1;
              div_cnt   <= '0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        PUSH: begin
          fifo_wr_en <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state      <= IDLE;
          sclk       <= 1'b0;
          cs_n       <= 1'b1;
          fifo_wr_en <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
